// File: rtl/if_fetch_unit.sv
// Instruction Fetch stage: PC, variable-latency imem handshake, stall/redirect handling.
// Optional define IF_FETCH_PERF_CNT_EN adds PERF_FETCHED / PERF_BUBBLES counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC_PLUS_4,
    output logic [31:0] PC,
    output logic        FETCH_VALID
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0] PERF_FETCHED,
    output logic [31:0] PERF_BUBBLES
`endif
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc, pc_nxt;
    logic [XLEN-1:0]   hold_reg, hold_nxt;
    logic [XLEN-1:0]   redirect_pc, redirect_nxt;
    logic [XLEN-1:0]   pc_inc;

    assign pc_inc = pc + XLEN'(4);

    // State and datapath registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            hold_reg    <= NOP_INSTR;
            redirect_pc <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            hold_reg    <= hold_nxt;
            redirect_pc <= redirect_nxt;
        end
    end

    // Next-state logic; a redirect always wins over a stall
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        hold_nxt     = hold_reg;
        redirect_nxt = redirect_pc;
        case (state)
            S_FETCH: begin
                if (BRANCH_TAKEN) begin
                    if (IMEM_BUSYWAIT) begin
                        redirect_nxt = BRANCH_TARGET;
                        state_nxt    = S_DRAIN;
                    end else begin
                        pc_nxt = BRANCH_TARGET;
                    end
                end else if (!IMEM_BUSYWAIT) begin
                    if (STALL) begin
                        hold_nxt  = IMEM_READDATA;
                        state_nxt = S_HOLD;
                    end else begin
                        pc_nxt = pc_inc;
                    end
                end
            end
            S_HOLD: begin
                if (BRANCH_TAKEN) begin
                    pc_nxt    = BRANCH_TARGET;
                    state_nxt = S_FETCH;
                end else if (!STALL) begin
                    pc_nxt    = pc_inc;
                    state_nxt = S_FETCH;
                end
            end
            S_DRAIN: begin
                // The in-flight access must finish before the new address goes out
                if (!IMEM_BUSYWAIT) begin
                    pc_nxt    = BRANCH_TAKEN ? BRANCH_TARGET : redirect_pc;
                    state_nxt = S_FETCH;
                end else if (BRANCH_TAKEN) begin
                    redirect_nxt = BRANCH_TARGET;
                end
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Outputs; held quiet while RESET is asserted
    always_comb begin
        IMEM_READ   = 1'b0;
        FETCH_VALID = 1'b0;
        INSTRUCTION = NOP_INSTR;
        IMEM_ADDR   = pc;
        PC          = pc;
        PC_PLUS_4   = pc_inc;
        if (!RESET) begin
            case (state)
                S_FETCH: begin
                    IMEM_READ   = 1'b1;
                    FETCH_VALID = !IMEM_BUSYWAIT;
                    if (!IMEM_BUSYWAIT) begin
                        INSTRUCTION = IMEM_READDATA;
                    end
                end
                S_HOLD: begin
                    FETCH_VALID = 1'b1;
                    INSTRUCTION = hold_reg;
                end
                S_DRAIN: begin
                    IMEM_READ = 1'b1;
                end
                default: begin
                    IMEM_READ = 1'b0;
                end
            endcase
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    // Delivered-instruction and bubble counters, free-running with wrap
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PERF_FETCHED <= '0;
            PERF_BUBBLES <= '0;
        end else begin
            if (FETCH_VALID && !STALL && !BRANCH_TAKEN) begin
                PERF_FETCHED <= PERF_FETCHED + XLEN'(1);
            end
            if (!FETCH_VALID) begin
                PERF_BUBBLES <= PERF_BUBBLES + XLEN'(1);
            end
        end
    end
`endif

endmodule
